hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC core (F/D/E/M/W). It replaces the purely combinational hazard detector with a small FSM that adds:
- configurable load-use bubble count
- multi-cycle execute-unit stalls
- control-flow flush
- M/W forwarding select
- a saturating stall-cycle counter

It sits beside the pipeline registers and drives PC, IM, F/D, D/E and E/M register enables and flushes.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, bubbles inserted on load-use hazard (legal 1..3)
MC_LAT, 4, E-stage occupancy in cycles of a multi-cycle op (legal 1..15; 1 = no stall)
ZERO_REG, 0, 1 = register 0 hardwired, never a hazard/forward source
CNT_W, 16, width of StallCnt

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
RA0_D, RA1_D  in  REG_AW  source addresses in D
RA0_E, RA1_E  in  REG_AW  source addresses in E
RS1Used_D, RS2Used_D, RS1Used_E, RS2Used_E  in  1  source-valid flags
WA_E, WA_M, WA_W  in  REG_AW  destination addresses per stage
Load_E  in  1  instruction in E is a load
WEN_M, WEN_W  in  1  register write enable, active-low (0 = writes)
MC_Start_E  in  1  instruction in E is a multi-cycle op
Jump, Branch, Taken  in  1  control-flow resolution in E
PCWrite, IMRead, FDWrite, DEWrite  out  1  stage enables
FDFlush, DEFlush, EMFlush  out  1  bubble insertion
FW1, FW2  out  2  ALU source select: 0 reg file, 1 from M, 2 from W
StallCnt  out  CNT_W  cycles with PCWrite=0, saturating

Behaviour:
- Register matching:
  - A match is equal addresses with the relevant Used flag set.
  - When ZERO_REG=1, address 0 never matches.
- Forwarding (combinational, all states):
  - FW1=1 if RS1Used_E, WEN_M=0 and RA0_E==WA_M.
  - Otherwise FW1=2 if RS1Used_E, WEN_W=0 and RA0_E==WA_W.
  - Otherwise FW1=0.
  - M has priority over W. FW2 uses the same rules with RA1_E and RS2Used_E.
- Defaults: PCWrite=IMRead=FDWrite=DEWrite=1; all flushes 0.
- FSM states: RUN, LD_STALL, MC_BUSY. A down-counter cnt is 4 bits wide.
- RUN, evaluated in this priority order:
  1. MC: MC_Start_E=1 and MC_LAT>=2.
     - Outputs: PCWrite=IMRead=FDWrite=DEWrite=0, EMFlush=1.
     - Next state MC_BUSY, cnt=MC_LAT-2.
  2. Redirect: Jump, or Branch&Taken.
     - Outputs: FDFlush=1, DEFlush=1, IMRead=0, PCWrite=1.
     - Stay in RUN. Any simultaneous load-use hazard is dropped.
  3. Load-use: Load_E and a D source matches WA_E.
     - Outputs: PCWrite=IMRead=FDWrite=0, DEFlush=1.
     - If LOAD_LAT>=2, next state LD_STALL with cnt=LOAD_LAT-2; otherwise stay in RUN.
- LD_STALL:
  - Load-use stall outputs asserted.
  - cnt==0 -> RUN; otherwise cnt--.
  - Redirect and MC_Start_E are ignored (E holds a bubble).
- MC_BUSY:
  - cnt!=0: MC stall outputs asserted, cnt--.
  - cnt==0: release cycle with default outputs (redirect is still honoured), next RUN.
  - MC_Start_E is ignored throughout MC_BUSY, including the release cycle, so the held op cannot retrigger.
  - Result: the op occupies E for MC_LAT cycles with exactly MC_LAT-1 stall cycles.
- MC_LAT=1: MC_Start_E has no effect.
- StallCnt: increments each cycle PCWrite=0 and RST=0; saturates at all-ones; never wraps.
- Reset (asynchronous, RST=1):
  - state=RUN, cnt=0, StallCnt=0.
  - While RST is high, outputs are forced to:
    - PCWrite=IMRead=FDWrite=DEWrite=0
    - FDFlush=DEFlush=EMFlush=1
    - FW1=FW2=0
  - Reset mid-stall aborts the stall; the first cycle after deassertion is RUN with defaults.
- Latency: hazard outputs are combinational from inputs and state in the same cycle. State and counters update on the CLK rising edge.

Test Plan:
- Forwarding: RS1Used_E=1, RA0_E=3, WA_M=3, WEN_M=0, WA_W=3, WEN_W=0 -> FW1=1. Set WEN_M=1 -> FW1=2. Set RA0_E=0 with ZERO_REG=1 -> FW1=0.
- Load-use, LOAD_LAT=2:
  - Stimulus: Load_E=1, WA_E=5, RS2Used_D=1, RA1_D=5 for one cycle, then Load_E=0.
  - Response: PCWrite=0 and DEFlush=1 for exactly 2 cycles, then defaults; StallCnt=2.
- Multi-cycle, MC_LAT=4:
  - Stimulus: MC_Start_E held high 4 cycles.
  - Response: DEWrite=0 and EMFlush=1 for cycles 1-3, defaults in cycle 4 with no retrigger; StallCnt=3.
- Simultaneous redirect and load-use:
  - Stimulus: Jump=1 with a load-use match.
  - Response: FDFlush=DEFlush=1, PCWrite=1, IMRead=0; next cycle RUN with no stall; StallCnt unchanged.
- Reset mid-operation:
  - Stimulus: assert RST during MC_BUSY cycle 2.
  - Response: immediately PCWrite=0, all flushes 1, StallCnt=0; after release, defaults in RUN.
- Saturation:
  - Stimulus: CNT_W=4, hold MC stalls for more than 20 stall cycles.
  - Response: StallCnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use bubbles,
// multi-cycle execute stalls, control-flow flush, M/W forwarding select
// and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MC_LAT   = 4,
    parameter bit          ZERO_REG = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] RA0_D,
    input  logic [REG_AW-1:0] RA1_D,
    input  logic [REG_AW-1:0] RA0_E,
    input  logic [REG_AW-1:0] RA1_E,
    input  logic              RS1Used_D,
    input  logic              RS2Used_D,
    input  logic              RS1Used_E,
    input  logic              RS2Used_E,
    input  logic [REG_AW-1:0] WA_E,
    input  logic [REG_AW-1:0] WA_M,
    input  logic [REG_AW-1:0] WA_W,
    input  logic              Load_E,
    input  logic              WEN_M,
    input  logic              WEN_W,
    input  logic              MC_Start_E,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              Taken,
    output logic              PCWrite,
    output logic              IMRead,
    output logic              FDWrite,
    output logic              DEWrite,
    output logic              FDFlush,
    output logic              DEFlush,
    output logic              EMFlush,
    output logic [1:0]        FW1,
    output logic [1:0]        FW2,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam int unsigned CNT_BITS = 4;
    localparam bit MC_EN    = (MC_LAT >= 2);
    localparam bit LD_MULTI = (LOAD_LAT >= 2);
    localparam logic [CNT_BITS-1:0] MC_INIT = CNT_BITS'(MC_EN    ? MC_LAT - 2   : 0);
    localparam logic [CNT_BITS-1:0] LD_INIT = CNT_BITS'(LD_MULTI ? LOAD_LAT - 2 : 0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic                ld_hazard;
    logic                redirect;
    logic                mc_go;

    // Address match gated by the source-valid flag; r0 optionally excluded.
    function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] b,
                                       input logic              used);
        return used && (a == b) && !(ZERO_REG && (a == '0));
    endfunction

    // Forwarding select: M stage wins over W stage.
    function automatic logic [1:0] fw_sel(input logic [REG_AW-1:0] ra,
                                          input logic              used,
                                          input logic [REG_AW-1:0] wa_m,
                                          input logic              wen_m,
                                          input logic [REG_AW-1:0] wa_w,
                                          input logic              wen_w);
        if (!wen_m && reg_match(ra, wa_m, used))
            return 2'd1;
        else if (!wen_w && reg_match(ra, wa_w, used))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Hazard conditions seen in the current cycle.
    always_comb begin
        ld_hazard = Load_E && (reg_match(RA0_D, WA_E, RS1Used_D) ||
                               reg_match(RA1_D, WA_E, RS2Used_D));
        redirect  = Jump || (Branch && Taken);
        mc_go     = MC_EN && MC_Start_E;
    end

    // Stage enables, flushes and forwarding selects from state and inputs.
    always_comb begin
        PCWrite = 1'b1;
        IMRead  = 1'b1;
        FDWrite = 1'b1;
        DEWrite = 1'b1;
        FDFlush = 1'b0;
        DEFlush = 1'b0;
        EMFlush = 1'b0;
        FW1     = fw_sel(RA0_E, RS1Used_E, WA_M, WEN_M, WA_W, WEN_W);
        FW2     = fw_sel(RA1_E, RS2Used_E, WA_M, WEN_M, WA_W, WEN_W);

        unique case (state)
            RUN: begin
                if (mc_go) begin
                    PCWrite = 1'b0; IMRead = 1'b0; FDWrite = 1'b0; DEWrite = 1'b0;
                    EMFlush = 1'b1;
                end else if (redirect) begin
                    FDFlush = 1'b1; DEFlush = 1'b1; IMRead = 1'b0;
                end else if (ld_hazard) begin
                    PCWrite = 1'b0; IMRead = 1'b0; FDWrite = 1'b0;
                    DEFlush = 1'b1;
                end
            end
            LD_STALL: begin
                // E holds a bubble, so redirect/MC requests are not real.
                PCWrite = 1'b0; IMRead = 1'b0; FDWrite = 1'b0;
                DEFlush = 1'b1;
            end
            MC_BUSY: begin
                if (cnt != '0) begin
                    PCWrite = 1'b0; IMRead = 1'b0; FDWrite = 1'b0; DEWrite = 1'b0;
                    EMFlush = 1'b1;
                end else if (redirect) begin
                    FDFlush = 1'b1; DEFlush = 1'b1; IMRead = 1'b0;
                end
            end
            default: ;
        endcase

        if (RST) begin
            PCWrite = 1'b0; IMRead = 1'b0; FDWrite = 1'b0; DEWrite = 1'b0;
            FDFlush = 1'b1; DEFlush = 1'b1; EMFlush = 1'b1;
            FW1     = 2'd0;
            FW2     = 2'd0;
        end
    end

    // FSM state, stall down-counter and saturating stall-cycle counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            cnt      <= '0;
            StallCnt <= '0;
        end else begin
            if (!PCWrite && (StallCnt != '1))
                StallCnt <= StallCnt + CNT_W'(1);

            unique case (state)
                RUN: begin
                    if (mc_go) begin
                        state <= MC_BUSY;
                        cnt   <= MC_INIT;
                    end else if (!redirect && ld_hazard && LD_MULTI) begin
                        state <= LD_STALL;
                        cnt   <= LD_INIT;
                    end
                end
                LD_STALL, MC_BUSY: begin
                    if (cnt == '0)
                        state <= RUN;
                    else
                        cnt <= cnt - CNT_BITS'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_LAT=2/MC_LAT=4,
// r0 hardwired and a 4-bit stall counter, plus a LOAD_LAT=1/MC_LAT=1 instance.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    // {PCWrite, IMRead, FDWrite, DEWrite, FDFlush, DEFlush, EMFlush}
    localparam logic [6:0] C_DEF = 7'b1111_000;
    localparam logic [6:0] C_LDS = 7'b0001_010;
    localparam logic [6:0] C_MCS = 7'b0000_001;
    localparam logic [6:0] C_RDR = 7'b1011_110;
    localparam logic [6:0] C_RST = 7'b0000_111;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] RA0_D, RA1_D, RA0_E, RA1_E, WA_E, WA_M, WA_W;
    logic          RS1Used_D, RS2Used_D, RS1Used_E, RS2Used_E;
    logic          Load_E, WEN_M, WEN_W, MC_Start_E, Jump, Branch, Taken;

    logic          d_pc, d_im, d_fd, d_de, d_fdf, d_def, d_emf;
    logic [1:0]    d_fw1, d_fw2;
    logic [3:0]    d_cnt;
    logic          l_pc, l_im, l_fd, l_de, l_fdf, l_def, l_emf;
    logic [1:0]    l_fw1, l_fw2;
    logic [15:0]   l_cnt;
    logic [6:0]    d_ctl, l_ctl;

    int errors = 0;
    int checks = 0;

    assign d_ctl = {d_pc, d_im, d_fd, d_de, d_fdf, d_def, d_emf};
    assign l_ctl = {l_pc, l_im, l_fd, l_de, l_fdf, l_def, l_emf};

    hazard_ctrl #(
        .REG_AW(AW), .LOAD_LAT(2), .MC_LAT(4), .ZERO_REG(1'b1), .CNT_W(4)
    ) u_dut (
        .CLK(CLK), .RST(RST),
        .RA0_D(RA0_D), .RA1_D(RA1_D), .RA0_E(RA0_E), .RA1_E(RA1_E),
        .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D),
        .RS1Used_E(RS1Used_E), .RS2Used_E(RS2Used_E),
        .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
        .Load_E(Load_E), .WEN_M(WEN_M), .WEN_W(WEN_W),
        .MC_Start_E(MC_Start_E), .Jump(Jump), .Branch(Branch), .Taken(Taken),
        .PCWrite(d_pc), .IMRead(d_im), .FDWrite(d_fd), .DEWrite(d_de),
        .FDFlush(d_fdf), .DEFlush(d_def), .EMFlush(d_emf),
        .FW1(d_fw1), .FW2(d_fw2), .StallCnt(d_cnt)
    );

    hazard_ctrl #(
        .REG_AW(AW), .LOAD_LAT(1), .MC_LAT(1), .ZERO_REG(1'b0), .CNT_W(16)
    ) u_lat1 (
        .CLK(CLK), .RST(RST),
        .RA0_D(RA0_D), .RA1_D(RA1_D), .RA0_E(RA0_E), .RA1_E(RA1_E),
        .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D),
        .RS1Used_E(RS1Used_E), .RS2Used_E(RS2Used_E),
        .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
        .Load_E(Load_E), .WEN_M(WEN_M), .WEN_W(WEN_W),
        .MC_Start_E(MC_Start_E), .Jump(Jump), .Branch(Branch), .Taken(Taken),
        .PCWrite(l_pc), .IMRead(l_im), .FDWrite(l_fd), .DEWrite(l_de),
        .FDFlush(l_fdf), .DEFlush(l_def), .EMFlush(l_emf),
        .FW1(l_fw1), .FW2(l_fw2), .StallCnt(l_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RA0_D = '0; RA1_D = '0; RA0_E = '0; RA1_E = '0;
        WA_E = '0; WA_M = '0; WA_W = '0;
        RS1Used_D = 1'b0; RS2Used_D = 1'b0; RS1Used_E = 1'b0; RS2Used_E = 1'b0;
        Load_E = 1'b0; WEN_M = 1'b1; WEN_W = 1'b1;
        MC_Start_E = 1'b0; Jump = 1'b0; Branch = 1'b0; Taken = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] exp_mc [5];
        exp_mc = '{C_MCS, C_MCS, C_MCS, C_RDR, C_DEF};

        // Reset forces stall/flush outputs and blocks forwarding
        idle();
        RST = 1'b1;
        RS1Used_E = 1'b1; RA0_E = 5'd3; WA_M = 5'd3; WEN_M = 1'b0;
        #2;
        check("rst_ctl", 16'(d_ctl), 16'(C_RST));
        check("rst_fw1", 16'(d_fw1), 16'd0);
        check("rst_cnt", 16'(d_cnt), 16'd0);
        tick(); tick();
        RST = 1'b0;
        idle();
        #3;
        check("run_def", 16'(d_ctl), 16'(C_DEF));

        // Forwarding: M beats W, W when M not writing, r0 excluded only if hardwired
        RS1Used_E = 1'b1; RA0_E = 5'd3; WA_M = 5'd3; WEN_M = 1'b0; WA_W = 5'd3; WEN_W = 1'b0;
        #1 check("fw1_m", 16'(d_fw1), 16'd1);
        WEN_M = 1'b1;
        #1 check("fw1_w", 16'(d_fw1), 16'd2);
        RA0_E = 5'd0; WA_W = 5'd0;
        #1 check("fw1_r0", 16'(d_fw1), 16'd0);
        check("fw1_r0_lat1", 16'(l_fw1), 16'd2);
        RS1Used_E = 1'b0; RS2Used_E = 1'b1; RA1_E = 5'd7; WA_M = 5'd7; WEN_M = 1'b0; WA_W = 5'd7;
        #1 check("fw2_m", 16'(d_fw2), 16'd1);
        check("fw1_unused", 16'(d_fw1), 16'd0);
        RS2Used_E = 1'b0;
        #1 check("fw2_unused", 16'(d_fw2), 16'd0);
        tick();

        // Load-use with LOAD_LAT=2 (LOAD_LAT=1 instance stalls once)
        idle();
        Load_E = 1'b1; WA_E = 5'd5; RS2Used_D = 1'b1; RA1_D = 5'd5;
        #3;
        check("ld_c1", 16'(d_ctl), 16'(C_LDS));
        check("ld_c1_lat1", 16'(l_ctl), 16'(C_LDS));
        tick();
        Load_E = 1'b0; Jump = 1'b1;
        #3;
        check("ld_c2_ignore_jump", 16'(d_ctl), 16'(C_LDS));
        check("ld_c2_lat1_jump", 16'(l_ctl), 16'(C_RDR));
        tick();
        Jump = 1'b0;
        #3;
        check("ld_c3", 16'(d_ctl), 16'(C_DEF));
        check("ld_cnt", 16'(d_cnt), 16'd2);
        check("ld_cnt_lat1", l_cnt, 16'd1);
        tick();

        // Multi-cycle op held 4 cycles; redirect honoured in release cycle
        idle();
        for (int i = 0; i < 5; i++) begin
            MC_Start_E = (i < 4);
            Branch = (i == 3);
            Taken  = (i == 3);
            #3;
            check($sformatf("mc_c%0d", i + 1), 16'(d_ctl), 16'(exp_mc[i]));
            check($sformatf("mc_lat1_c%0d", i + 1), 16'(l_ctl), 16'((i == 3) ? C_RDR : C_DEF));
            tick();
        end
        check("mc_cnt", 16'(d_cnt), 16'd5);

        // Redirect wins over simultaneous load-use; Branch needs Taken
        idle();
        Jump = 1'b1; Load_E = 1'b1; WA_E = 5'd9; RS1Used_D = 1'b1; RA0_D = 5'd9;
        #3;
        check("jmp_ld", 16'(d_ctl), 16'(C_RDR));
        tick();
        idle();
        #3;
        check("jmp_ld_next", 16'(d_ctl), 16'(C_DEF));
        check("jmp_ld_cnt", 16'(d_cnt), 16'd5);
        Branch = 1'b1;
        #1 check("br_not_taken", 16'(d_ctl), 16'(C_DEF));
        Taken = 1'b1;
        #1 check("br_taken", 16'(d_ctl), 16'(C_RDR));
        tick();

        // Reset during MC_BUSY cycle 2 aborts the stall
        idle();
        MC_Start_E = 1'b1; RS1Used_E = 1'b1; RA0_E = 5'd3; WA_M = 5'd3; WEN_M = 1'b0;
        #3;
        check("mcr_c1", 16'(d_ctl), 16'(C_MCS));
        check("mcr_fw1", 16'(d_fw1), 16'd1);
        tick();
        RST = 1'b1;
        #1;
        check("mcr_rst_ctl", 16'(d_ctl), 16'(C_RST));
        check("mcr_rst_cnt", 16'(d_cnt), 16'd0);
        check("mcr_rst_fw1", 16'(d_fw1), 16'd0);
        tick();
        RST = 1'b0;
        idle();
        #2;
        check("mcr_after", 16'(d_ctl), 16'(C_DEF));
        tick();
        #2;
        check("mcr_after2", 16'(d_ctl), 16'(C_DEF));
        check("mcr_after_cnt", 16'(d_cnt), 16'd0);

        // Saturation: 28 cycles of back-to-back MC ops give 21 stall cycles
        idle();
        MC_Start_E = 1'b1;
        repeat (28) tick();
        check("sat_cnt", 16'(d_cnt), 16'd15);
        repeat (4) tick();
        check("sat_hold", 16'(d_cnt), 16'd15);
        check("lat1_mc_nostall", l_cnt, 16'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
